// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited request issue,
// a {pc, insn} FIFO toward decode, and redirect flushing of wrong-path work.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc, resp_pc;
    logic [CW-1:0] inflight, drop, count, inflight_left;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   insn_mem [DEPTH];
    logic [31:0]   target;
    logic          grant, push, pop;

    // a response always has a FIFO slot because in-flight requests hold credits
    assign imem_req      = !reset && !redirect_en && ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(DEPTH);
    assign imem_addr     = pc;
    assign grant         = imem_req && imem_gnt;
    assign push          = imem_rvalid && !redirect_en && drop == '0;
    assign insn_valid    = !reset && !redirect_en && count != '0;
    assign pop           = insn_valid && insn_ready;
    assign insn          = insn_mem[rd_ptr];
    assign insn_pc       = pc_mem[rd_ptr];
    assign target        = redirect_pc & 32'hFFFF_FFFC;
    assign inflight_left = inflight - CW'(imem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_en) begin
            // every request still outstanding now answers on the wrong path
            pc       <= target;
            resp_pc  <= target;
            inflight <= inflight_left;
            drop     <= inflight_left;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (grant)
                pc <= pc + 32'd4;
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (imem_rvalid && drop != '0)
                drop <= drop - CW'(1);
            inflight <= inflight_left + CW'(grant);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            insn_mem[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the mspu core. It sits directly upstream of the instruction decoder. It owns the program counter and issues in-order word fetches to instruction memory over a request/grant + response interface. Returned instructions are buffered, each with its PC, in a small FIFO. The FIFO feeds decode through a valid/ready handshake, and the stage accepts PC redirects from branch/jal/jalr resolution, flushing everything fetched down the wrong path.

## Interface
- RESET_PC, 32'h0000_0000, PC of first fetch after reset; bits [1:0] must be 0
- DEPTH, 4, FIFO entries and maximum outstanding fetches; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request (combinational)
- imem_addr  out  32  fetch address (registered PC)
- imem_gnt  in  1  memory accepts request this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  response data valid; responses return in request order, earliest the cycle after grant
- imem_rdata  in  32  instruction word
- redirect_en  in  1  taken branch / jal / jalr this cycle
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 00)
- insn_valid  out  1  FIFO head valid to decode
- insn_ready  in  1  decode consumes head when valid&&ready
- insn  out  32  instruction word at FIFO head
- insn_pc  out  32  PC of insn

## Operation
- State:
  - pc: next fetch address
  - resp_pc: PC of next live response
  - inflight: granted requests not yet answered, 0..DEPTH
  - drop: responses still to be discarded, 0..DEPTH
  - FIFO of {pc, insn} with count
- Grant: imem_req && imem_gnt → pc <= pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), inflight += 1.
- imem_req = !redirect_en && (inflight + count) < DEPTH. Credit rule: every response always has a FIFO slot; no backpressure on imem_rvalid.
- inflight_next = inflight + grant − imem_rvalid.
- Response handling:
  - If imem_rvalid && !redirect_en && drop==0: push {resp_pc, imem_rdata}, resp_pc += 4.
  - If imem_rvalid && (redirect_en || drop>0): discard. If drop>0, drop -= 1.
- Pop: insn_valid && insn_ready → head removed. Push and pop in the same cycle are both performed; count unchanged.
- insn_valid = (count != 0) && !redirect_en. insn/insn_pc = head entry; their value is don't-care when insn_valid=0.
- Redirect (priority over everything):
  - pc <= {redirect_pc[31:2], 2'b00}; resp_pc <= same value
  - FIFO flushed (count <= 0); no pop occurs
  - drop <= inflight − imem_rvalid; every request still in flight becomes a dropped response
  - imem_req forced 0 that cycle, so no grant
- Redirect while drop>0: the new drop value includes the old dropped responses, because inflight already counts them.
- Back-to-back redirects: the last one wins. Each redirect recomputes drop from inflight.
- Reset: pc, resp_pc, and imem_addr = RESET_PC; inflight = drop = count = 0; imem_req = 0 and insn_valid = 0 while reset is high. Memory shares the same reset, so no responses arrive for pre-reset requests.
- imem_rvalid while inflight==0 is a protocol error; the bench asserts against it.

## Timing
- First request: the cycle after reset deasserts, imem_req=1 with imem_addr=RESET_PC.
- Full throughput: one grant per cycle while credits remain. With 1-cycle memory and insn_ready=1, decode sees one instruction per cycle.
- Latency: grant at T → rvalid earliest T+1 → insn_valid at T+2. The FIFO is registered, with no rvalid-to-insn bypass.
- Redirect at T:
  - imem_req=0 and insn_valid=0 at T
  - imem_req=1 with imem_addr=redirect_pc at T+1 (if credits allow)
  - first redirected instruction valid at T+3 at the earliest
- Stall: with insn_ready=0, the FIFO fills to DEPTH − inflight. Requests stop when inflight + count == DEPTH and resume the cycle after a pop frees a credit.

## Test plan
- Reset → streaming: RESET_PC=0x100, 1-cycle memory returning addr^0xA5A5_0000, insn_ready=1.
  - imem_addr 0x100,0x104,0x108… on consecutive cycles
  - first insn_valid 2 cycles after first grant, insn_pc=0x100, insn=0xA5A5_0100
  - then one instruction per cycle
- Backpressure: hold insn_ready=0 for 10 cycles.
  - exactly DEPTH instructions fetched; imem_req low once inflight+count==4
  - release → 0x100..0x10C delivered in order, fetching resumes at 0x110
- Redirect with in-flight requests: 3-cycle memory latency, 3 requests outstanding, redirect_pc=0x2002.
  - all 3 stale responses discarded (drop 3→0)
  - next imem_addr=0x2000
  - first delivered insn_pc=0x2000; no stale PC reaches decode
- Redirect coincident with push and pop: redirect_en, imem_rvalid, and insn_ready all high in the same cycle with count=2.
  - insn_valid=0 that cycle
  - FIFO empty next cycle; the returned word is dropped
- Back-to-back redirects to 0x400 then 0x800 on consecutive cycles → only 0x800.. fetched and delivered.
- PC wrap: redirect to 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with matching insn_pc values; reset asserted mid-stream clears all state and restarts at RESET_PC.
